// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures operands and decoded control, detects
// load-use hazards against EX, and inserts bubbles on hazard or branch flush.
module id_ex_stage #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_ext,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [REG_AW-1:0] in_rs1,
   input  logic [REG_AW-1:0] in_rs2,
   input  logic              in_use_rs1,
   input  logic              in_use_rs2,
   input  logic [REG_AW-1:0] in_rd,
   input  logic              in_reg_write,
   input  logic              in_mem_read,
   input  logic              in_mem_write,
   input  logic [3:0]        in_alu_op,
   input  logic [DATA_W-1:0] in_imm,
   input  logic [DATA_W-1:0] src_data1,
   input  logic [DATA_W-1:0] src_data2,
   output logic              id_stall,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_pc,
   output logic [DATA_W-1:0] ex_imm,
   output logic [DATA_W-1:0] ex_op1,
   output logic [DATA_W-1:0] ex_op2,
   output logic [REG_AW-1:0] ex_rs1,
   output logic [REG_AW-1:0] ex_rs2,
   output logic [REG_AW-1:0] ex_rd,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic [3:0]        ex_alu_op,
   output logic [CNT_W-1:0]  bubble_count
);

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic              regWrite;
      logic              memRead;
      logic              memWrite;
      logic [3:0]        aluOp;
   } exReg_t;

   exReg_t           exQ, exD;
   logic [CNT_W-1:0] bubbleCnt;
   logic             loadInEx, srcHit, hz, bubble;

   // A load in EX whose result is not available until MEM forces one bubble.
   assign loadInEx = exQ.valid & exQ.memRead & exQ.regWrite & (exQ.rd != '0);
   assign srcHit   = (in_use_rs1 & (in_rs1 == exQ.rd)) | (in_use_rs2 & (in_rs2 == exQ.rd));
   assign hz       = in_valid & loadInEx & srcHit;
   assign bubble   = flush | hz;
   assign id_stall = stall_ext | (hz & ~flush);

   always_comb begin
      exD          = '0;
      exD.valid    = in_valid;
      exD.pc       = in_pc;
      exD.imm      = in_imm;
      exD.op1      = src_data1;
      exD.op2      = src_data2;
      exD.rs1      = in_rs1;
      exD.rs2      = in_rs2;
      exD.rd       = in_rd;
      exD.regWrite = in_reg_write & in_valid;
      exD.memRead  = in_mem_read & in_valid;
      exD.memWrite = in_mem_write & in_valid;
      exD.aluOp    = in_alu_op;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         exQ       <= '0;
         bubbleCnt <= '0;
      end else if (!stall_ext) begin
         exQ <= bubble ? '0 : exD;
         // Only load-use bubbles are counted; flush bubbles are not.
         if (hz && !flush && bubbleCnt != '1)
            bubbleCnt <= bubbleCnt + CNT_W'(1);
      end
   end

   assign ex_valid     = exQ.valid;
   assign ex_pc        = exQ.pc;
   assign ex_imm       = exQ.imm;
   assign ex_op1       = exQ.op1;
   assign ex_op2       = exQ.op2;
   assign ex_rs1       = exQ.rs1;
   assign ex_rs2       = exQ.rs2;
   assign ex_rd        = exQ.rd;
   assign ex_reg_write = exQ.regWrite;
   assign ex_mem_read  = exQ.memRead;
   assign ex_mem_write = exQ.memWrite;
   assign ex_alu_op    = exQ.aluOp;
   assign bubble_count = bubbleCnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model predicts EX contents
// each cycle; a narrow-counter instance shares inputs to exercise saturation.
module tb_id_ex_stage;

   logic        clk, rst, stall_ext, flush, in_valid;
   logic [15:0] in_pc, in_imm, src_data1, src_data2;
   logic [3:0]  in_rs1, in_rs2, in_rd, in_alu_op;
   logic        in_use_rs1, in_use_rs2, in_reg_write, in_mem_read, in_mem_write;

   logic        id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
   logic [15:0] ex_pc, ex_imm, ex_op1, ex_op2, bubble_count;
   logic [3:0]  ex_rs1, ex_rs2, ex_rd, ex_alu_op;

   logic        sIdStall, sVld, sRw, sMr, sMw;
   logic [15:0] sPc, sImm, sOp1, sOp2;
   logic [3:0]  sRs1, sRs2, sRd, sAlu, sCnt;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .stall_ext(stall_ext), .flush(flush), .in_valid(in_valid),
      .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1),
      .in_use_rs2(in_use_rs2), .in_rd(in_rd), .in_reg_write(in_reg_write),
      .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_alu_op(in_alu_op),
      .in_imm(in_imm), .src_data1(src_data1), .src_data2(src_data2),
      .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
      .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_alu_op(ex_alu_op), .bubble_count(bubble_count));

   id_ex_stage #(.CNT_W(4)) dutSat (
      .clk(clk), .rst(rst), .stall_ext(stall_ext), .flush(flush), .in_valid(in_valid),
      .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1),
      .in_use_rs2(in_use_rs2), .in_rd(in_rd), .in_reg_write(in_reg_write),
      .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_alu_op(in_alu_op),
      .in_imm(in_imm), .src_data1(src_data1), .src_data2(src_data2),
      .id_stall(sIdStall), .ex_valid(sVld), .ex_pc(sPc), .ex_imm(sImm),
      .ex_op1(sOp1), .ex_op2(sOp2), .ex_rs1(sRs1), .ex_rs2(sRs2), .ex_rd(sRd),
      .ex_reg_write(sRw), .ex_mem_read(sMr), .ex_mem_write(sMw),
      .ex_alu_op(sAlu), .bubble_count(sCnt));

   typedef struct packed {
      logic        vld;
      logic [15:0] pc, imm, op1, op2;
      logic [3:0]  rs1, rs2, rd;
      logic        rw, mr, mw;
      logic [3:0]  alu;
      logic [15:0] cnt;
      logic [3:0]  cnt4;
   } exS;

   exS   m;
   exS   sb[$];
   int   checks = 0;
   int   errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic cmpEx(input exS e);
      chk("ex_valid", 32'(ex_valid), 32'(e.vld));
      chk("ex_pc", 32'(ex_pc), 32'(e.pc));
      chk("ex_imm", 32'(ex_imm), 32'(e.imm));
      chk("ex_op1", 32'(ex_op1), 32'(e.op1));
      chk("ex_op2", 32'(ex_op2), 32'(e.op2));
      chk("ex_rs1", 32'(ex_rs1), 32'(e.rs1));
      chk("ex_rs2", 32'(ex_rs2), 32'(e.rs2));
      chk("ex_rd", 32'(ex_rd), 32'(e.rd));
      chk("ex_reg_write", 32'(ex_reg_write), 32'(e.rw));
      chk("ex_mem_read", 32'(ex_mem_read), 32'(e.mr));
      chk("ex_mem_write", 32'(ex_mem_write), 32'(e.mw));
      chk("ex_alu_op", 32'(ex_alu_op), 32'(e.alu));
      chk("bubble_count", 32'(bubble_count), 32'(e.cnt));
      chk("bubble_count4", 32'(sCnt), 32'(e.cnt4));
   endtask

   // Check id_stall against the model, predict the next EX state, clock once.
   task automatic cyc();
      logic hzE;
      exS   nxt;
      #1;
      hzE = in_valid & m.vld & m.mr & m.rw & (m.rd != 4'd0) &
            ((in_use_rs1 & (in_rs1 == m.rd)) | (in_use_rs2 & (in_rs2 == m.rd)));
      chk("id_stall", 32'(id_stall), 32'(stall_ext | (hzE & ~flush)));
      nxt = m;
      if (!stall_ext) begin
         if (flush || hzE) begin
            nxt = '0;
            nxt.cnt  = m.cnt;
            nxt.cnt4 = m.cnt4;
            if (!flush) begin
               if (m.cnt != 16'hFFFF) nxt.cnt = m.cnt + 16'd1;
               if (m.cnt4 != 4'hF) nxt.cnt4 = m.cnt4 + 4'd1;
            end
         end else begin
            nxt.vld = in_valid;
            nxt.pc  = in_pc;   nxt.imm = in_imm;
            nxt.op1 = src_data1; nxt.op2 = src_data2;
            nxt.rs1 = in_rs1;  nxt.rs2 = in_rs2; nxt.rd = in_rd;
            nxt.rw  = in_reg_write & in_valid;
            nxt.mr  = in_mem_read & in_valid;
            nxt.mw  = in_mem_write & in_valid;
            nxt.alu = in_alu_op;
         end
      end
      sb.push_back(nxt);
      m = nxt;
      @(posedge clk);
      #1;
      if (sb.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
      else cmpEx(sb.pop_front());
   endtask

   task automatic instr(input logic [3:0] rd, input logic [3:0] rs1, input logic u1,
                        input logic [3:0] rs2, input logic u2, input logic rw, input logic mr);
      in_valid = 1'b1; in_rd = rd; in_rs1 = rs1; in_use_rs1 = u1;
      in_rs2 = rs2; in_use_rs2 = u2; in_reg_write = rw; in_mem_read = mr;
      in_mem_write = 1'b0; in_alu_op = 4'($urandom);
      in_pc = 16'($urandom); in_imm = 16'($urandom);
      src_data1 = 16'($urandom); src_data2 = 16'($urandom);
   endtask

   task automatic randIn();
      in_valid = 1'($urandom); in_pc = 16'($urandom); in_imm = 16'($urandom);
      in_rs1 = 4'($urandom_range(0, 3)); in_rs2 = 4'($urandom_range(0, 3));
      in_rd = 4'($urandom_range(0, 3)); in_use_rs1 = 1'($urandom); in_use_rs2 = 1'($urandom);
      in_reg_write = 1'($urandom); in_mem_read = 1'($urandom); in_mem_write = 1'($urandom);
      in_alu_op = 4'($urandom); src_data1 = 16'($urandom); src_data2 = 16'($urandom);
   endtask

   task automatic chkZero(input string tag);
      chk({tag, "_valid"}, 32'(ex_valid), 32'd0);
      chk({tag, "_data"}, 32'(ex_pc | ex_imm | ex_op1 | ex_op2), 32'd0);
      chk({tag, "_idx"}, 32'({ex_rs1, ex_rs2, ex_rd, ex_alu_op}), 32'd0);
      chk({tag, "_ctl"}, 32'({ex_reg_write, ex_mem_read, ex_mem_write}), 32'd0);
      chk({tag, "_cnt"}, 32'(bubble_count), 32'd0);
      chk({tag, "_cnt4"}, 32'(sCnt), 32'd0);
   endtask

   initial begin
      logic [15:0] holdPc, holdCnt;
      rst = 1'b0; stall_ext = 1'b0; flush = 1'b0;
      m = '0;
      // Reset held with random activity on all inputs
      for (int i = 0; i < 4; i++) begin
         randIn();
         stall_ext = 1'($urandom); flush = 1'($urandom);
         @(posedge clk); #1;
         chkZero("reset");
         chk("reset_id_stall", 32'(id_stall), 32'(stall_ext));
      end
      stall_ext = 1'b0; flush = 1'b0;
      rst = 1'b1;

      // ADD r3 with operand 0x1234
      instr(4'd3, 4'd1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0);
      src_data1 = 16'h1234;
      cyc();
      chk("add_op1", 32'(ex_op1), 32'h1234);
      chk("add_rd", 32'(ex_rd), 32'd3);

      // Load-use: LW r5 then ADD using r5
      instr(4'd5, 4'd1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
      cyc();
      instr(4'd6, 4'd5, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0);
      cyc();
      chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
      chk("lu_bubble_count", 32'(bubble_count), 32'd1);
      cyc();
      chk("lu_consumer_rs1", 32'(ex_rs1), 32'd5);
      chk("lu_consumer_valid", 32'(ex_valid), 32'd1);
      #1 chk("lu_no_stall", 32'(id_stall), 32'd0);

      // Non-hazards: r0 load, unused rs2 match, non-load producer
      instr(4'd0, 4'd1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1); cyc();
      instr(4'd6, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0); cyc();
      instr(4'd5, 4'd1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1); cyc();
      instr(4'd6, 4'd1, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0); cyc();
      instr(4'd5, 4'd1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0); cyc();
      instr(4'd6, 4'd5, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0); cyc();
      chk("nonhz_count", 32'(bubble_count), 32'd1);
      chk("nonhz_valid", 32'(ex_valid), 32'd1);

      // Flush wins over a hazard and is not counted
      instr(4'd5, 4'd1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1); cyc();
      instr(4'd6, 4'd5, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
      flush = 1'b1;
      #1 chk("flush_id_stall", 32'(id_stall), 32'd0);
      cyc();
      flush = 1'b0;
      chk("flush_valid", 32'(ex_valid), 32'd0);
      chk("flush_count", 32'(bubble_count), 32'd1);

      // External stall overrides flush; EX frozen
      instr(4'd4, 4'd1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0); cyc();
      holdPc = ex_pc; holdCnt = bubble_count;
      stall_ext = 1'b1; flush = 1'b1;
      for (int i = 0; i < 3; i++) begin
         randIn();
         cyc();
         chk("stall_pc_hold", 32'(ex_pc), 32'(holdPc));
         chk("stall_cnt_hold", 32'(bubble_count), 32'(holdCnt));
      end
      stall_ext = 1'b0; flush = 1'b0;

      // 17 load-use bubbles saturate the 4-bit counter
      for (int i = 0; i < 17; i++) begin
         instr(4'd7, 4'd1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1); cyc();
         instr(4'd8, 4'd2, 1'b0, 4'd7, 1'b1, 1'b1, 1'b0); cyc();
         cyc();
      end
      chk("sat_cnt4", 32'(sCnt), 32'hF);
      chk("sat_cnt16", 32'(bubble_count), 32'd18);

      // Randomised traffic with frequent hazards, flushes and stalls
      for (int i = 0; i < 300; i++) begin
         randIn();
         flush = ($urandom_range(0, 7) == 0);
         stall_ext = ($urandom_range(0, 7) == 0);
         cyc();
      end
      stall_ext = 1'b0; flush = 1'b0;

      // Reset asserted mid-stall, between edges
      instr(4'd9, 4'd1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1); cyc();
      stall_ext = 1'b1;
      cyc();
      #2 rst = 1'b0;
      #1 chkZero("midreset");
      m = '0;
      @(posedge clk); #1;
      chkZero("midreset_hold");
      rst = 1'b1; stall_ext = 1'b0;
      instr(4'd6, 4'd9, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
      cyc();
      chk("postreset_valid", 32'(ex_valid), 32'd1);

      if (sb.size() != 0) chk("scoreboard_drain", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule
